// File: rtl/lc3_pkg.sv
// Shared types and defaults for the LC-3 memory subsystem.
// Imported by the memory unit and its storage array.
package lc3_pkg;

  localparam int LC3_WORD_W = 16;
  localparam int LC3_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_array.sv
// Word storage with a synchronous write port and a registered read port.
// A cleared read loads zero instead of the addressed word.
module mem_array
  import lc3_pkg::*;
#(
  parameter int DATA_W = LC3_WORD_W,
  parameter int DEPTH  = 65536,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = clr ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 main memory with a REQ/READY handshake and programmable wait states.
// Out-of-range accesses complete normally but raise ERR and never alias.
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int DATA_W  = LC3_WORD_W,
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              READY,
  output logic              BUSY,
  output logic              ERR
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("lc3_mem_unit: LATENCY must be 1..15");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("lc3_mem_unit: DEPTH must be 1..2**ADDR_W");
  end

  mem_state_t        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              we_d, we_q;
  logic              ready_d, ready_q;
  logic              err_d, err_q;
  logic              acc;
  logic              oor;

  // Widened compare so DEPTH == 2**ADDR_W is representable.
  assign oor = {1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d  = ADDR;
          data_d  = DATA_IN;
          we_d    = WE;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          acc     = 1'b1;
          ready_d = 1'b1;
          err_d   = oor;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (CLK),
    .rst   (RST),
    .we    (acc & we_q & ~oor),
    .re    (acc & ~we_q),
    .clr   (oor),
    .idx   (addr_q[IDX_W-1:0]),
    .wdata (data_q),
    .rdata (DATA_OUT)
  );

  assign READY = ready_q;
  assign ERR   = err_q;
  assign BUSY  = (state_q != IDLE);

  a_known_req : assert property (
    @(posedge CLK) disable iff (RST)
    (state_q == IDLE) |-> !$isunknown({REQ, WE})
  );

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Scoreboard bench for lc3_mem_unit at three latency/depth points.
// Stimulus pushes expected completions; a negedge monitor checks them.
module tb_lc3_mem_unit;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [3];
  logic        we_i   [3];
  logic [15:0] addr   [3];
  logic [15:0] din    [3];
  logic [15:0] dout   [3];
  logic        rdy    [3];
  logic        busy   [3];
  logic        err    [3];

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb [3][$];
  int          brun [3];
  logic [15:0] last_rd [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    localparam int DEP = (g == 0) ? 65536 : 256;
    lc3_mem_unit #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH   (DEP),
      .LATENCY (LAT)
    ) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .REQ      (req[g]),
      .WE       (we_i[g]),
      .ADDR     (addr[g]),
      .DATA_IN  (din[g]),
      .DATA_OUT (dout[g]),
      .READY    (rdy[g]),
      .BUSY     (busy[g]),
      .ERR      (err[g])
    );
  end

  function automatic int lat(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%0h want=%0h t=%0t",
               nm, g, act, exp, $time);
    end
  endtask

  task automatic issue(input int g, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic ee);
    exp_t e;
    @(negedge clk);
    req[g]  = 1'b1;
    we_i[g] = w;
    addr[g] = a;
    din[g]  = d;
    @(posedge clk);
    #1;
    req[g] = 1'b0;
    if (!w) last_rd[g] = ee ? 16'h0000 : d;
    e.rd   = !w;
    e.data = last_rd[g];
    e.err  = ee;
    e.cyc  = cyc + lat(g);
    sb[g].push_back(e);
  endtask

  task automatic wr(input int g, input logic [15:0] a,
                    input logic [15:0] d, input logic ee);
    issue(g, 1'b1, a, d, ee);
  endtask

  task automatic rd(input int g, input logic [15:0] a,
                    input logic [15:0] ed, input logic ee);
    issue(g, 1'b0, a, ed, ee);
  endtask

  task automatic wait_done(input int g);
    int n = 0;
    while (sb[g].size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb[g].size() != 0) begin
      chk("timeout", g, sb[g].size(), 0);
      sb[g].delete();
    end
    @(posedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (busy[g] === 1'b1) brun[g]++;
        if (rdy[g] === 1'b1) begin
          if (sb[g].size() == 0) begin
            chk("spurious_ready", g, 1, 0);
          end else begin
            e = sb[g].pop_front();
            chk("ready_cycle", g, cyc, e.cyc);
            chk("err", g, {31'd0, err[g]}, {31'd0, e.err});
            chk(e.rd ? "rd_data" : "data_hold_on_wr", g,
                {16'd0, dout[g]}, {16'd0, e.data});
            chk("busy_len", g, brun[g], lat(g) + 1);
          end
        end
        if (busy[g] !== 1'b1) brun[g] = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] vals [4];
    exp_t e;
    int base;
    vals[0] = 16'hC001;
    vals[1] = 16'hC0DE;
    vals[2] = 16'h7E57;
    vals[3] = 16'h0FF0;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      req[g]     = 1'b0;
      we_i[g]    = 1'b0;
      addr[g]    = '0;
      din[g]     = '0;
      last_rd[g] = '0;
      brun[g]    = 0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_data_out", g, {16'd0, dout[g]}, 0);
      chk("rst_ready", g, {31'd0, rdy[g]}, 0);
      chk("rst_busy", g, {31'd0, busy[g]}, 0);
      chk("rst_err", g, {31'd0, err[g]}, 0);
    end
    rst = 1'b0;

    wr(0, 16'h3000, 16'hBEEF, 1'b0); wait_done(0);
    rd(0, 16'h3000, 16'hBEEF, 1'b0); wait_done(0);

    wr(1, 16'h0005, 16'h0777, 1'b0); wait_done(1);
    rd(1, 16'h0005, 16'h0777, 1'b0); wait_done(1);
    wr(2, 16'h0005, 16'h7777, 1'b0); wait_done(2);
    rd(2, 16'h0005, 16'h7777, 1'b0); wait_done(2);

    wr(0, 16'h0010, 16'h1234, 1'b0); wait_done(0);
    wr(0, 16'h0020, 16'h0BAD, 1'b0); wait_done(0);
    rd(0, 16'h0010, 16'h1234, 1'b0);
    @(negedge clk);
    addr[0] = 16'h0020;
    we_i[0] = 1'b1;
    din[0]  = 16'hFFFF;
    wait_done(0);
    we_i[0] = 1'b0;
    rd(0, 16'h0020, 16'h0BAD, 1'b0); wait_done(0);

    wr(1, 16'h0000, 16'h1357, 1'b0); wait_done(1);
    wr(1, 16'h0100, 16'hAAAA, 1'b1); wait_done(1);
    rd(1, 16'h0100, 16'h0000, 1'b1); wait_done(1);
    rd(1, 16'h0000, 16'h1357, 1'b0); wait_done(1);
    wr(1, 16'h00FF, 16'h2468, 1'b0); wait_done(1);
    rd(1, 16'h00FF, 16'h2468, 1'b0); wait_done(1);
    rd(2, 16'h1000, 16'h0000, 1'b1); wait_done(2);

    wr(0, 16'h0040, 16'h0001, 1'b0); wait_done(0);
    @(negedge clk);
    req[0]  = 1'b1;
    we_i[0] = 1'b1;
    addr[0] = 16'h0040;
    din[0]  = 16'h5555;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_data_out", 0, {16'd0, dout[0]}, 0);
    chk("midrst_ready", 0, {31'd0, rdy[0]}, 0);
    chk("midrst_busy", 0, {31'd0, busy[0]}, 0);
    chk("midrst_err", 0, {31'd0, err[0]}, 0);
    @(negedge clk);
    rst     = 1'b0;
    we_i[0] = 1'b0;
    for (int g = 0; g < 3; g++) last_rd[g] = '0;
    repeat (4) @(negedge clk);
    rd(0, 16'h0040, 16'h0001, 1'b0); wait_done(0);

    for (int k = 0; k < 4; k++) begin
      wr(0, 16'(k), vals[k], 1'b0); wait_done(0);
    end
    base = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req[0]  = 1'b1;
      we_i[0] = 1'b0;
      addr[0] = 16'(k);
      @(posedge clk);
      #1;
      if (k == 0) base = cyc;
      e.rd   = 1'b1;
      e.data = vals[k];
      e.err  = 1'b0;
      e.cyc  = base + k * (lat(0) + 2) + lat(0);
      last_rd[0] = vals[k];
      sb[0].push_back(e);
      repeat (lat(0) + 1) @(posedge clk);
    end
    #1;
    req[0] = 1'b0;
    wait_done(0);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("leftover", g, sb[g].size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
